pong_motion_ctrl: RTL

PONG_MOTION_CTRL -- requirements
Module: pong_motion_ctrl

---
 rtl/pong_pkg.sv | 40 ++++
 rtl/refr_tick_gen.sv | 25 ++
 rtl/pong_motion_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared screen and object geometry for the pong motion controller and the
// graphics generator. Coordinates are carried as 10-bit pixel positions.
// All comparisons are done on CRD_W-bit copies so that x+7 and x+71 cannot wrap.
package pong_pkg;

    // Width used for every geometry comparison
    localparam int CRD_W = 11;

    // Visible screen
    localparam logic [CRD_W-1:0] MAX_X      = 11'd640;
    localparam logic [CRD_W-1:0] MAX_Y      = 11'd480;

    // Top wall occupies rows 32..35
    localparam logic [CRD_W-1:0] WALL_Y_T   = 11'd32;
    localparam logic [CRD_W-1:0] WALL_Y_B   = 11'd35;

    // Bar: 72 pixels wide, rows 450..453
    localparam logic [CRD_W-1:0] BAR_Y_T    = 11'd450;
    localparam logic [CRD_W-1:0] BAR_Y_B    = 11'd453;
    localparam logic [CRD_W-1:0] BAR_X_SIZE = 11'd72;
    localparam logic [CRD_W-1:0] BAR_X_MAX  = MAX_X - BAR_X_SIZE;

    // Ball: 8x8 square
    localparam logic [CRD_W-1:0] BALL_SIZE  = 11'd8;

    // Home positions
    localparam logic [9:0] BALL_X_HOME = 10'd316;
    localparam logic [9:0] BALL_Y_HOME = 10'd425;
    localparam logic [9:0] BAR_X_HOME  = 10'd284;

    // Scan position that marks the start of vertical blanking
    localparam logic [9:0] REFR_PIX_X = 10'd0;
    localparam logic [9:0] REFR_PIX_Y = 10'd481;

    // Zero-extend a pixel position to comparison width
    function automatic logic [CRD_W-1:0] ext_crd(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/refr_tick_gen.sv
// Frame tick: one clock pulse on the first clock the scan counters sit at
// (x=0, y=481). Holding that position does not re-trigger.
import pong_pkg::*;

module refr_tick_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       refr_tick
);

    logic at_refr;
    logic at_refr_q;

    assign at_refr   = (pix_y == REFR_PIX_Y) && (pix_x == REFR_PIX_X);
    assign refr_tick = at_refr & ~at_refr_q;

    // Remember last clock's match so only the rising edge produces a tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) at_refr_q <= 1'b0;
        else       at_refr_q <= at_refr;
    end

endmodule

// File: rtl/pong_motion_ctrl.sv
// Pong ball/bar motion controller. Positions, directions and game state
// advance once per frame tick; outputs change on the edge that ends the tick.
import pong_pkg::*;

module pong_motion_ctrl #(
    parameter int BALL_SPEED  = 2,
    parameter int BAR_SPEED   = 4,
    parameter int MISS_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       start,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] bar_x,
    output logic       playing,
    output logic       miss
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_MISS = 2'd2;

    localparam int CNT_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MISS_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [CRD_W-1:0] BALL_V  = CRD_W'(BALL_SPEED);
    localparam logic [CRD_W-1:0] BAR_V   = CRD_W'(BAR_SPEED);
    localparam logic [9:0]       BALL_V10 = 10'(BALL_SPEED);
    localparam logic [9:0]       BAR_V10  = 10'(BAR_SPEED);

    logic             refr_tick;

    logic [1:0]       state_q, state_n;
    logic [9:0]       ball_x_q, ball_x_n;
    logic [9:0]       ball_y_q, ball_y_n;
    logic [9:0]       bar_x_q, bar_x_n;
    logic             dx_neg_q, dx_neg_n;
    logic             dy_neg_q, dy_neg_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             miss_q, miss_n;

    // One-frame motion candidates for PLAY
    logic [CRD_W-1:0] bx, by, bar_w;
    logic             dx_neg_step, dy_neg_step;
    logic [9:0]       ball_x_step, ball_y_step;
    logic             at_bottom;

    refr_tick_gen u_tick (
        .clk       (clk),
        .reset     (reset),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .refr_tick (refr_tick)
    );

    // Bar movement: saturating at both screen edges, opposing buttons cancel
    always_comb begin
        bar_w   = ext_crd(bar_x_q);
        bar_x_n = bar_x_q;
        if (btn_right && !btn_left) begin
            if (bar_w + BAR_V >= BAR_X_MAX) bar_x_n = 10'(BAR_X_MAX);
            else                            bar_x_n = bar_x_q + BAR_V10;
        end else if (btn_left && !btn_right) begin
            if (bar_w <= BAR_V) bar_x_n = 10'd0;
            else                bar_x_n = bar_x_q - BAR_V10;
        end
    end

    // Ball step: wall bounces, bar hit against the current bar position, then move
    always_comb begin
        bx = ext_crd(ball_x_q);
        by = ext_crd(ball_y_q);

        dx_neg_step = dx_neg_q;
        if (bx <= BALL_V)
            dx_neg_step = 1'b0;
        else if (bx + BALL_SIZE - 11'd1 >= MAX_X - 11'd1 - BALL_V)
            dx_neg_step = 1'b1;
        ball_x_step = dx_neg_step ? ball_x_q - BALL_V10 : ball_x_q + BALL_V10;

        dy_neg_step = dy_neg_q;
        if (by <= WALL_Y_B + 11'd1)
            dy_neg_step = 1'b0;
        if (!dy_neg_step &&
            (by + BALL_SIZE - 11'd1 >= BAR_Y_T) &&
            (by + BALL_SIZE - 11'd1 <= BAR_Y_B) &&
            (bx + BALL_SIZE - 11'd1 >= bar_w) &&
            (bx <= bar_w + BAR_X_SIZE - 11'd1))
            dy_neg_step = 1'b1;
        ball_y_step = dy_neg_step ? ball_y_q - BALL_V10 : ball_y_q + BALL_V10;

        at_bottom = (by + BALL_SIZE - 11'd1 >= MAX_Y - 11'd1);
    end

    // Game FSM: decides what the ball does on this frame
    always_comb begin
        state_n  = state_q;
        ball_x_n = ball_x_q;
        ball_y_n = ball_y_q;
        dx_neg_n = dx_neg_q;
        dy_neg_n = dy_neg_q;
        cnt_n    = cnt_q;
        miss_n   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ball_x_n = BALL_X_HOME;
                ball_y_n = BALL_Y_HOME;
                dx_neg_n = 1'b0;
                dy_neg_n = 1'b1;
                if (start) state_n = ST_PLAY;
            end
            ST_PLAY: begin
                if (at_bottom) begin
                    // Ball stays where it fell out; hold off for MISS_FRAMES frames
                    state_n = ST_MISS;
                    miss_n  = 1'b1;
                    cnt_n   = CNT_LOAD;
                end else begin
                    ball_x_n = ball_x_step;
                    ball_y_n = ball_y_step;
                    dx_neg_n = dx_neg_step;
                    dy_neg_n = dy_neg_step;
                end
            end
            ST_MISS: begin
                if (cnt_q == '0) begin
                    state_n  = ST_IDLE;
                    ball_x_n = BALL_X_HOME;
                    ball_y_n = BALL_Y_HOME;
                    dx_neg_n = 1'b0;
                    dy_neg_n = 1'b1;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State registers: everything advances on the frame tick; miss lasts one clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ball_x_q <= BALL_X_HOME;
            ball_y_q <= BALL_Y_HOME;
            bar_x_q  <= BAR_X_HOME;
            dx_neg_q <= 1'b0;
            dy_neg_q <= 1'b1;
            cnt_q    <= '0;
            miss_q   <= 1'b0;
        end else begin
            miss_q <= refr_tick & miss_n;
            if (refr_tick) begin
                state_q  <= state_n;
                ball_x_q <= ball_x_n;
                ball_y_q <= ball_y_n;
                bar_x_q  <= bar_x_n;
                dx_neg_q <= dx_neg_n;
                dy_neg_q <= dy_neg_n;
                cnt_q    <= cnt_n;
            end
        end
    end

    assign ball_x  = ball_x_q;
    assign ball_y  = ball_y_q;
    assign bar_x   = bar_x_q;
    assign playing = (state_q == ST_PLAY);
    assign miss    = miss_q;

endmodule
